// File: rtl/cpu_pkg.sv
// Shared core types: decoded op codes, fetch FSM states
// and the canonical NOP encoding.
package cpu_pkg;

  typedef enum logic [4:0] {
    CU_ADD,
    CU_SUB,
    CU_ADDI,
    CU_LUI,
    CU_AUIPC,
    CU_LOAD,
    CU_STORE,
    CU_JAL,
    CU_JALR,
    CU_BEQ,
    CU_BNE,
    CU_BLT,
    CU_BGE,
    CU_BLTU,
    CU_BGEU,
    CU_ERROR
  } cuOPType;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    EXEC,
    HALT
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/next_pc.sv
// Next-PC target selection for jumps and branches,
// plus the misaligned-target flag.
module next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic        negative,
  input  cuOPType     cu_op,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] pc4;
  logic [31:0] pcimm;

  assign pc4   = pc + 32'd4;
  assign pcimm = pc + imm;

  // negative carries A<B in the branch's own signedness
  always_comb begin
    target = pc4;
    unique case (cu_op)
      CU_JAL:  target = pcimm;
      CU_JALR: target = alu_result & ~32'h1;
      CU_BEQ:  target = zero ? pcimm : pc4;
      CU_BNE:  target = zero ? pc4 : pcimm;
      CU_BLT,
      CU_BLTU: target = negative ? pcimm : pc4;
      CU_BGE,
      CU_BGEU: target = negative ? pc4 : pcimm;
      default: target = pc4;
    endcase
  end

  assign misaligned = target[1];

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage: req/ack instruction fetch, next-PC
// update on retire, retired count and halt/trap.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  cuOPType     cu_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic        negative,
  input  logic        exec_done,
  output logic [31:0] instret,
  output logic        halted,
  output logic        misaligned
);

  fetch_state_t state, state_n;
  logic [31:0]  target;
  logic         tgt_mis;
  logic         fire;
  logic         retire;
  logic         trap;

  next_pc u_next_pc (
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .zero       (zero),
    .negative   (negative),
    .cu_op      (cu_op),
    .target     (target),
    .misaligned (tgt_mis)
  );

  // imem_req is only ever high in FETCH/WAIT
  assign fire   = imem_req & imem_ack;
  assign retire = (state == EXEC) & exec_done;
  assign trap   = (cu_op == CU_ERROR) | tgt_mis;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH,
      WAIT: begin
        if (fire)          state_n = EXEC;
        else if (imem_req) state_n = WAIT;
      end
      EXEC: begin
        if (exec_done) state_n = trap ? HALT : FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // req is registered from the next state, so it stays low
  // for the first cycle out of reset
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      imem_req   <= 1'b0;
      instr      <= NOP;
      pc         <= RESET_PC;
      instret    <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      imem_req <= (state_n == FETCH) || (state_n == WAIT);
      if (fire) instr <= imem_rdata;
      if (retire && !trap) begin
        pc      <= target;
        instret <= instret + 32'd1;
      end
      if (retire && cu_op != CU_ERROR && tgt_mis)
        misaligned <= 1'b1;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized and directed
// instruction streams against an operand-level reference model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  cuOPType     cu_op;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        zero;
  logic        negative;
  logic        exec_done;
  logic [31:0] instret;
  logic        halted;
  logic        misaligned;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .cu_op       (cu_op),
    .imm         (imm),
    .alu_result  (alu_result),
    .zero        (zero),
    .negative    (negative),
    .exec_done   (exec_done),
    .instret     (instret),
    .halted      (halted),
    .misaligned  (misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halt;
    logic        mis;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] iq[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halt;
  logic        m_mis;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void push_ev();
    ev_t e;
    e.pc   = m_pc;
    e.cnt  = m_cnt;
    e.halt = m_halt;
    e.mis  = m_mis;
    evq.push_back(e);
  endfunction

  // Reference: branch outcome from the real operands,
  // not from the flags handed to the DUT.
  function automatic void model_retire(cuOPType op,
    logic [31:0] im, logic [31:0] alu,
    logic [31:0] a, logic [31:0] b);
    logic [31:0] seq;
    logic [31:0] tk;
    logic [31:0] t;
    seq = m_pc + 32'd4;
    tk  = m_pc + im;
    case (op)
      CU_JAL:  t = tk;
      CU_JALR: t = {alu[31:1], 1'b0};
      CU_BEQ:  t = (a == b) ? tk : seq;
      CU_BNE:  t = (a != b) ? tk : seq;
      CU_BLT:  t = ($signed(a) < $signed(b)) ? tk : seq;
      CU_BGE:  t = ($signed(a) >= $signed(b)) ? tk : seq;
      CU_BLTU: t = (a < b) ? tk : seq;
      CU_BGEU: t = (a >= b) ? tk : seq;
      default: t = seq;
    endcase
    if (op == CU_ERROR) begin
      m_halt = 1'b1;
    end else if (t[1]) begin
      m_halt = 1'b1;
      m_mis  = 1'b1;
    end else begin
      m_pc  = t;
      m_cnt = m_cnt + 32'd1;
    end
    push_ev();
  endfunction

  task automatic do_reset(bit ack_pending);
    imem_ack  = ack_pending;
    exec_done = 1'b0;
    nRst      = 1'b0;
    #1;
    check("rst_pc", pc, RST);
    check("rst_addr", imem_addr, RST);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    evq.delete();
    iq.delete();
    m_pc   = RST;
    m_cnt  = 32'd0;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    push_ev();
    @(negedge clk);
    @(negedge clk);
    check("rst_ack_dropped", instr, NOP);
    imem_ack = 1'b0;
    nRst     = 1'b1;
  endtask

  task automatic fetch(int waits, bit ack_extra);
    logic [31:0] w;
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      check("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    repeat (waits) @(negedge clk);
    w          = $urandom;
    imem_ack   = 1'b1;
    imem_rdata = w;
    iq.push_back(w);
    @(negedge clk);
    imem_ack   = ack_extra;
    imem_rdata = $urandom;
  endtask

  task automatic exec(cuOPType op, logic [31:0] im,
    logic [31:0] alu, logic [31:0] a, logic [31:0] b,
    int delay, bit hold);
    bit uns;
    uns        = (op == CU_BLTU) || (op == CU_BGEU);
    cu_op      = op;
    imm        = im;
    alu_result = alu;
    zero       = (a == b);
    negative   = uns ? (a < b) : ($signed(a) < $signed(b));
    exec_done  = 1'b0;
    repeat (delay) @(negedge clk);
    exec_done = 1'b1;
    imem_ack  = 1'b0;
    model_retire(op, im, alu, a, b);
    @(negedge clk);
    if (hold) @(negedge clk);
    exec_done = 1'b0;
  endtask

  task automatic step(cuOPType op, logic [31:0] im,
    logic [31:0] alu, logic [31:0] a, logic [31:0] b);
    fetch(0, 1'b0);
    exec(op, im, alu, a, b, 0, 1'b0);
  endtask

  task automatic rand_instr();
    cuOPType     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] alu;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    im  = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
    alu = $urandom;
    alu[1] = 1'b0;
    case ($urandom_range(0, 9))
      0: op = CU_ADDI;
      1: op = CU_ADD;
      2: op = CU_JAL;
      3: op = CU_JALR;
      4: op = CU_BEQ;
      5: op = CU_BNE;
      6: op = CU_BLT;
      7: op = CU_BGE;
      8: op = CU_BLTU;
      default: op = CU_BGEU;
    endcase
    fetch($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    exec(op, im, alu, a, b, $urandom_range(0, 2),
         1'($urandom_range(0, 1)));
  endtask

  // Monitor: pops expectations whenever the DUT shows a
  // new fetch, a halt, or a newly valid instruction.
  initial begin
    logic        pr;
    logic        ph;
    logic        pv;
    logic [31:0] pa;
    logic [31:0] cur;
    ev_t         e;
    pr = 0; ph = 0; pv = 0; pa = 0; cur = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!nRst) begin
        pr = 0; ph = 0; pv = 0;
      end else begin
        if ((imem_req && !pr) || (halted && !ph)) begin
          if (evq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ev_unexpected actual=pc %h required=none",
                     pc);
          end else begin
            e = evq.pop_front();
            check("ev_pc", pc, e.pc);
            check("ev_instret", instret, e.cnt);
            check("ev_halted", 32'(halted), 32'(e.halt));
            check("ev_mis", 32'(misaligned), 32'(e.mis));
          end
        end
        if (imem_req && pr) check("addr_stable", imem_addr, pa);
        if (halted) check("halt_no_req", 32'(imem_req), 32'd0);
        if (instr_valid && !pv) begin
          if (iq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL instr_unexpected actual=%h required=none",
                     instr);
          end else begin
            cur = iq.pop_front();
            check("instr", instr, cur);
          end
        end else if (instr_valid) begin
          check("instr_hold", instr, cur);
        end
        if (instr_valid) check("valid_no_req", 32'(imem_req), 32'd0);
        pr = imem_req;
        ph = halted;
        pv = instr_valid;
        pa = imem_addr;
      end
    end
  end

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_cnt;
    nRst       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    cu_op      = CU_ADDI;
    imm        = 32'd0;
    alu_result = 32'd0;
    zero       = 1'b0;
    negative   = 1'b0;
    exec_done  = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // straight line
    repeat (3) step(CU_ADDI, 32'd0, 32'd0, 32'd1, 32'd2);
    check("instret3", instret, 32'd3);
    check("pc_c", pc, 32'h0c);

    // wait states at 0x10
    step(CU_JALR, 32'd0, 32'h10, 32'd0, 32'd0);
    fetch(3, 1'b0);
    exec(CU_ADDI, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    check("pc_14", pc, 32'h14);

    // conditional branches from 0x20, imm -8
    step(CU_JALR, 32'd0, 32'h20, 32'd0, 32'd0);
    step(CU_BEQ, -32'sd8, 32'd0, 32'd5, 32'd5);
    check("beq_taken", pc, 32'h18);
    step(CU_JALR, 32'd0, 32'h20, 32'd0, 32'd0);
    step(CU_BNE, -32'sd8, 32'd0, 32'd5, 32'd5);
    check("bne_not", pc, 32'h24);
    step(CU_JALR, 32'd0, 32'h20, 32'd0, 32'd0);
    step(CU_BGEU, -32'sd8, 32'd0, 32'd7, 32'd3);
    check("bgeu_taken", pc, 32'h18);
    step(CU_JALR, 32'd0, 32'h20, 32'd0, 32'd0);
    step(CU_BLT, -32'sd8, 32'd0, 32'd5, 32'd1);
    check("blt_not", pc, 32'h24);

    // jumps
    step(CU_JALR, 32'd0, 32'h105, 32'd0, 32'd0);
    check("jalr_lsb", pc, 32'h104);
    step(CU_JALR, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd0);
    step(CU_JAL, 32'd8, 32'd0, 32'd0, 32'd0);
    check("jal_wrap", pc, 32'h4);

    repeat (40) rand_instr();

    // CU_ERROR trap
    fetch(1, 1'b0);
    hold_pc  = m_pc;
    hold_cnt = m_cnt;
    exec(CU_ERROR, 32'd16, 32'd0, 32'd0, 32'd0, 1, 1'b1);
    repeat (4) @(negedge clk);
    check("err_halted", 32'(halted), 32'd1);
    check("err_pc", pc, hold_pc);
    check("err_instret", instret, hold_cnt);
    check("err_mis", 32'(misaligned), 32'd0);

    // misaligned jump target
    do_reset(1'b0);
    step(CU_JAL, 32'd6, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_pc", pc, RST);
    check("mis_instret", instret, 32'd0);

    // reset while in WAIT with an ack pending
    do_reset(1'b0);
    step(CU_ADDI, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("wait_req", 32'(imem_req), 32'd1);
    do_reset(1'b1);

    // exec_done during FETCH is ignored
    @(negedge clk);
    cu_op     = CU_JAL;
    imm       = 32'h100;
    exec_done = 1'b1;
    repeat (2) @(negedge clk);
    exec_done = 1'b0;
    check("fetch_done_pc", pc, RST);
    fetch(0, 1'b0);
    exec(CU_ADDI, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    check("after_ign_pc", pc, RST + 32'd4);
    check("after_ign_cnt", instret, 32'd1);

    repeat (3) @(negedge clk);
    check("evq_drained", 32'(evq.size()), 32'd0);
    check("iq_drained", 32'(iq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
